// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl
//   Sequences the OFIFO -> SFP -> PSUM SRAM read-modify-write path. One start
//   command drains num_vec vectors from the OFIFO into consecutive PSUM SRAM
//   addresses starting at base_addr, in INIT (overwrite), ACCUM (accumulate)
//   or FINAL (accumulate + ReLU) mode.
//
// Ports
//   clk, reset        clock (posedge) and synchronous active-high reset
//   start             1-cycle command pulse, accepted only when idle
//   mode              0=INIT 1=ACCUM 2=FINAL 3=reserved (handled as ACCUM)
//   base_addr         first PSUM SRAM address
//   num_vec           number of vectors to move
//   ofifo_valid       OFIFO head valid
//   ofifo_rd          pop OFIFO head
//   pmem_cen          PSUM SRAM chip enable (active low)
//   pmem_ren/wen      PSUM SRAM read / write strobes (active high)
//   pmem_addr         PSUM SRAM address
//   sfp_acc           SFP add psum + ofifo
//   sfp_passthru      SFP pass ofifo data through
//   sfp_relu          SFP clamp negative results to 0
//   busy              command in flight
//   done              1-cycle completion pulse
module psum_accum_ctrl #(
    parameter int AW    = 11,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    base_addr,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             ofifo_valid,
    output logic             ofifo_rd,
    output logic             pmem_cen,
    output logic             pmem_ren,
    output logic             pmem_wen,
    output logic [AW-1:0]    pmem_addr,
    output logic             sfp_acc,
    output logic             sfp_passthru,
    output logic             sfp_relu,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] M_INIT  = 2'd0;
    localparam logic [1:0] M_ACCUM = 2'd1;
    localparam logic [1:0] M_FINAL = 2'd2;

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [AW-1:0]    addr_q;
    logic [CNT_W-1:0] rem_q;

    // next-cycle values of the registered outputs
    logic             ofifo_rd_d, cen_d, ren_d, wen_d;
    logic [AW-1:0]    addr_d;
    logic             acc_d, pass_d, relu_d, busy_d, done_d;

    // Next state. Outputs are derived from the next state so that every
    // output can be registered and still line up with the state it belongs to.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (num_vec == '0) ? S_DONE : S_WAIT;
            S_WAIT: if (ofifo_valid) state_d = (mode_q == M_INIT) ? S_WR : S_RD;
            S_RD:   state_d = S_WR;
            S_WR:   state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_WAIT;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ofifo_rd_d = 1'b0;
        cen_d      = 1'b1;
        ren_d      = 1'b0;
        wen_d      = 1'b0;
        addr_d     = pmem_addr;   // address holds outside RD/WR
        acc_d      = 1'b0;
        pass_d     = 1'b0;
        relu_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            S_WAIT: busy_d = 1'b1;
            S_RD: begin
                busy_d = 1'b1;
                cen_d  = 1'b0;
                ren_d  = 1'b1;
                addr_d = addr_q;
            end
            S_WR: begin
                busy_d     = 1'b1;
                cen_d      = 1'b0;
                wen_d      = 1'b1;
                addr_d     = addr_q;
                ofifo_rd_d = 1'b1;
                case (mode_q)
                    M_INIT:  pass_d = 1'b1;
                    M_FINAL: begin
                        acc_d  = 1'b1;
                        relu_d = 1'b1;
                    end
                    default: acc_d = 1'b1;
                endcase
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_INIT;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                // reserved mode code folds into ACCUM at latch time
                mode_q <= (mode == 2'd3) ? M_ACCUM : mode;
                addr_q <= base_addr;
                rem_q  <= num_vec;
            end else if (state_q == S_WR) begin
                addr_q <= addr_q + AW'(1);   // wraps at the top of the SRAM
                rem_q  <= rem_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ofifo_rd     <= 1'b0;
            pmem_cen     <= 1'b1;
            pmem_ren     <= 1'b0;
            pmem_wen     <= 1'b0;
            pmem_addr    <= '0;
            sfp_acc      <= 1'b0;
            sfp_passthru <= 1'b0;
            sfp_relu     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            ofifo_rd     <= ofifo_rd_d;
            pmem_cen     <= cen_d;
            pmem_ren     <= ren_d;
            pmem_wen     <= wen_d;
            pmem_addr    <= addr_d;
            sfp_acc      <= acc_d;
            sfp_passthru <= pass_d;
            sfp_relu     <= relu_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Bench for psum_accum_ctrl: a behavioural SRAM + OFIFO + SFP environment
// reacts to the controller strobes, while an expected-memory model is built
// directly from the command semantics (overwrite / add / add+clamp).
module tb_psum_accum_ctrl;
    localparam int AW    = 11;
    localparam int CNT_W = 12;
    localparam int DEPTH = 2048;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = '0;
    logic [AW-1:0]    base_addr = '0;
    logic [CNT_W-1:0] num_vec = '0;
    logic             ofifo_valid = 1'b0;
    logic             ofifo_rd, pmem_cen, pmem_ren, pmem_wen;
    logic [AW-1:0]    pmem_addr;
    logic             sfp_acc, sfp_passthru, sfp_relu, busy, done;

    psum_accum_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .num_vec(num_vec), .ofifo_valid(ofifo_valid),
        .ofifo_rd(ofifo_rd), .pmem_cen(pmem_cen), .pmem_ren(pmem_ren),
        .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .sfp_acc(sfp_acc),
        .sfp_passthru(sfp_passthru), .sfp_relu(sfp_relu), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int mem[DEPTH];
    int exp_mem[DEPTH];
    int fifo[$];
    int rows[$];
    bit gate = 1'b1;
    int qreg;
    int cyc, ren_cnt, wen_cnt, pop_cnt, done_cnt, viol, last_wr_cyc, done_cyc;
    bit prev_ren;
    int n_chk, n_fail;
    int env_d, env_head;

    // Environment: SRAM, OFIFO and SFP reacting to this cycle's strobes.
    always @(negedge clk) begin
        cyc++;
        if (pmem_ren && pmem_wen) viol++;
        if ((pmem_ren || pmem_wen) && pmem_cen) viol++;
        if (ofifo_rd && !pmem_wen) viol++;
        if (ofifo_rd && fifo.size() == 0) viol++;
        if (pmem_wen && sfp_acc && !prev_ren) viol++;
        if (pmem_wen && !pmem_cen) begin
            env_head = (fifo.size() != 0) ? fifo[0] : 0;
            if (sfp_passthru) env_d = env_head;
            else if (sfp_acc) env_d = qreg + env_head;
            else env_d = -9999;
            if (sfp_relu && env_d < 0) env_d = 0;
            mem[pmem_addr] = env_d;
            wen_cnt++;
            last_wr_cyc = cyc;
        end
        if (ofifo_rd && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pop_cnt++;
        end
        if (pmem_ren && !pmem_cen) begin
            qreg = mem[pmem_addr];
            ren_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_ren = pmem_ren;
        ofifo_valid = (fifo.size() != 0) && gate;
    end

    task automatic preload(input int a, input int v);
        mem[a] = v;
        exp_mem[a] = v;
    endtask

    // Issue one command and check it end to end against the expected memory.
    task automatic run_cmd(input int m, input int base, input int num,
                           input int stall_at, input bit rnd_gate, input string nm);
        int w0, p0, d0, v0, c0, a, r, sw, sr, sp, to;
        bit stalled;
        stalled = 0;
        for (int i = 0; i < num; i++) begin
            r = (i < rows.size()) ? rows[i] : $urandom_range(0, 200) - 100;
            fifo.push_back(r);
            a = (base + i) % DEPTH;
            if (m == 0) exp_mem[a] = r;
            else if (m == 2) exp_mem[a] = (exp_mem[a] + r < 0) ? 0 : exp_mem[a] + r;
            else exp_mem[a] = exp_mem[a] + r;
        end
        rows.delete();
        w0 = wen_cnt; p0 = pop_cnt; d0 = done_cnt; v0 = viol;
        @(posedge clk); #1;
        start = 1; mode = 2'(m); base_addr = AW'(base); num_vec = CNT_W'(num);
        @(posedge clk); #1;
        c0 = cyc;
        start = 0; mode = 2'($urandom); base_addr = AW'($urandom); num_vec = CNT_W'($urandom);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_start: got %b expected 1", nm, busy);
        end
        to = 1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) begin to = 0; break; end
            if (rnd_gate) gate = ($urandom_range(0, 3) != 0);
            if (stall_at >= 0 && !stalled && wen_cnt - w0 == stall_at) begin
                stalled = 1; gate = 0;
                sw = wen_cnt; sr = ren_cnt; sp = pop_cnt;
                repeat (5) @(posedge clk);
                #1;
                n_chk++;
                if (wen_cnt != sw || ren_cnt != sr || pop_cnt != sp || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s stall_strobes: got w%0d r%0d p%0d busy%b expected w%0d r%0d p%0d busy1",
                             nm, wen_cnt, ren_cnt, pop_cnt, busy, sw, sr, sp);
                end
                gate = 1;
            end
        end
        gate = 1;
        n_chk++;
        if (to) begin n_fail++; $display("FAIL %s timeout: got no done expected done", nm); end
        n_chk++;
        if (wen_cnt - w0 != num || pop_cnt - p0 != num) begin
            n_fail++;
            $display("FAIL %s strobe_count: got wr %0d pop %0d expected %0d", nm, wen_cnt - w0, pop_cnt - p0, num);
        end
        n_chk++;
        if (done_cyc != last_wr_cyc + 1) begin
            n_fail++; $display("FAIL %s done_latency: got %0d expected %0d", nm, done_cyc, last_wr_cyc + 1);
        end
        if (stall_at < 0 && !rnd_gate) begin
            n_chk++;
            if (done_cyc - c0 != ((m == 0) ? 2 : 3) * num + 1) begin
                n_fail++;
                $display("FAIL %s throughput: got %0d expected %0d", nm, done_cyc - c0, ((m == 0) ? 2 : 3) * num + 1);
            end
        end
        n_chk++;
        if (viol != v0 || fifo.size() != 0) begin
            n_fail++; $display("FAIL %s protocol: got viol %0d fifo %0d expected 0 0", nm, viol - v0, fifo.size());
        end
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s idle_after_done: got done %b busy %b expected 0 0", nm, done, busy);
        end
        for (int i = -1; i <= num; i++) begin
            a = (base + i + DEPTH) % DEPTH;
            n_chk++;
            if (mem[a] != exp_mem[a]) begin
                n_fail++; $display("FAIL %s mem[%0d]: got %0d expected %0d", nm, a, mem[a], exp_mem[a]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({ofifo_rd, pmem_cen, pmem_ren, pmem_wen, sfp_acc, sfp_passthru, sfp_relu, busy, done} !== 9'b0_1000_0000
            || pmem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b addr %0d expected 010000000 addr 0",
                     {ofifo_rd, pmem_cen, pmem_ren, pmem_wen, sfp_acc, sfp_passthru, sfp_relu, busy, done}, pmem_addr);
        end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_init();
        rows = '{111, 222, 333};
        run_cmd(0, 5, 3, -1, 0, "init");
    endtask

    task automatic test_accum();
        preload(0, 10); preload(1, -4);
        rows = '{3, 3};
        run_cmd(1, 0, 2, -1, 0, "accum");
        n_chk++;
        if (mem[0] != 13 || mem[1] != -1) begin
            n_fail++; $display("FAIL accum_values: got %0d %0d expected 13 -1", mem[0], mem[1]);
        end
    endtask

    task automatic test_final();
        preload(0, -8); preload(1, 1);
        rows = '{2, 2};
        run_cmd(2, 0, 2, -1, 0, "final");
        n_chk++;
        if (mem[0] != 0 || mem[1] != 3) begin
            n_fail++; $display("FAIL final_values: got %0d %0d expected 0 3", mem[0], mem[1]);
        end
    endtask

    task automatic test_wrap_stall();
        run_cmd(1, 2046, 4, 2, 0, "wrap_stall");
    endtask

    task automatic test_zero_and_busy();
        int d0, w0, r0, keep;
        // num_vec == 0: done the cycle right after acceptance, no strobes
        d0 = done_cnt; w0 = wen_cnt; r0 = ren_cnt;
        @(posedge clk); #1;
        start = 1; mode = 2'd1; base_addr = 11'd9; num_vec = '0;
        @(posedge clk); #1;
        start = 0;
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got done %b busy %b expected 1 0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (done_cnt - d0 != 1 || wen_cnt != w0 || ren_cnt != r0) begin
            n_fail++; $display("FAIL zero_strobes: got done %0d wr %0d rd %0d expected 1 0 0",
                               done_cnt - d0, wen_cnt - w0, ren_cnt - r0);
        end
        // second start while busy must be ignored
        keep = mem[300];
        d0 = done_cnt; w0 = wen_cnt;
        fifo.push_back(41); fifo.push_back(42);
        exp_mem[100] = 41; exp_mem[101] = 42;
        gate = 0;
        @(posedge clk); #1;
        start = 1; mode = 2'd0; base_addr = 11'd100; num_vec = 12'd2;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        start = 1; mode = 2'd2; base_addr = 11'd300; num_vec = 12'd5;
        @(posedge clk); #1;
        start = 0;
        gate = 1;
        for (int k = 0; k < 50 && done_cnt == d0; k++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk);
        #1;
        n_chk++;
        if (done_cnt - d0 != 1 || wen_cnt - w0 != 2) begin
            n_fail++; $display("FAIL busy_start_ignored: got done %0d wr %0d expected 1 2", done_cnt - d0, wen_cnt - w0);
        end
        n_chk++;
        if (mem[100] != 41 || mem[101] != 42 || mem[300] != keep) begin
            n_fail++; $display("FAIL busy_start_mem: got %0d %0d %0d expected 41 42 %0d", mem[100], mem[101], mem[300], keep);
        end
    endtask

    task automatic test_reset_mid();
        int w0, nren, orig51;
        bit hit;
        preload(50, 7); preload(51, 20); preload(52, 30);
        orig51 = 20;
        fifo.push_back(5); fifo.push_back(6); fifo.push_back(7);
        w0 = wen_cnt; nren = 0; hit = 0;
        @(posedge clk); #1;
        start = 1; mode = 2'd1; base_addr = 11'd50; num_vec = 12'd3;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (pmem_ren === 1'b1) nren++;
            if (nren == 2) begin hit = 1; break; end
        end
        reset = 1;
        @(posedge clk); #1;
        n_chk++;
        if (!hit || {ofifo_rd, pmem_cen, pmem_ren, pmem_wen, sfp_acc, sfp_passthru, sfp_relu, busy, done} !== 9'b0_1000_0000
            || pmem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got hit %b %b addr %0d expected hit 1 010000000 addr 0", hit,
                     {ofifo_rd, pmem_cen, pmem_ren, pmem_wen, sfp_acc, sfp_passthru, sfp_relu, busy, done}, pmem_addr);
        end
        reset = 0;
        repeat (6) @(posedge clk);
        #1;
        n_chk++;
        if (wen_cnt - w0 != 1 || mem[50] != 12 || mem[51] != orig51) begin
            n_fail++; $display("FAIL reset_mid_mem: got wr %0d m50 %0d m51 %0d expected 1 12 %0d",
                               wen_cnt - w0, mem[50], mem[51], orig51);
        end
        exp_mem[50] = 12;
        fifo.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++)
            run_cmd($urandom_range(0, 3), $urandom_range(0, DEPTH - 1), $urandom_range(1, 6), -1, 1, "random");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom_range(0, 100) - 50);
        test_reset();
        test_init();
        test_accum();
        test_final();
        test_wrap_stall();
        test_zero_and_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
